// File: rtl/img_bf_pkg.sv
// -----------------------------------------------------------------------------
// img_bf_pkg
// Shared types and elaboration helpers for the DMA-to-image-buffer loader.
//   - bf_state_e      : loader FSM states (IDLE, LOAD)
//   - calc_beats      : DMA beats per image-buffer word
//   - calc_cnt_w      : beat-counter width, $clog2(BEATS) with a minimum of 1
//   - width_ok        : buffer word width must be a whole multiple of the beat
// Optional feature macro used by the loader: IMG_BF_PINGPONG_EN
// -----------------------------------------------------------------------------
package img_bf_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } bf_state_e;

    localparam int DEF_DMA_WIDTH       = 16;
    localparam int DEF_BF_DATA_WIDTH   = 48;
    localparam int DEF_IMEM_ADDR_WIDTH = 8;

    function automatic int calc_beats(input int bf_w, input int dma_w);
        return bf_w / dma_w;
    endfunction

    function automatic int calc_cnt_w(input int beats);
        if (beats > 1) begin
            return $clog2(beats);
        end else begin
            return 1;
        end
    endfunction

    function automatic bit width_ok(input int bf_w, input int dma_w);
        return (dma_w > 0) && (bf_w >= dma_w) && ((bf_w % dma_w) == 0);
    endfunction

    localparam int DEF_BEATS      = calc_beats(DEF_BF_DATA_WIDTH, DEF_DMA_WIDTH);
    localparam int DEF_BEAT_CNT_W = calc_cnt_w(DEF_BEATS);

endpackage

// File: rtl/img_bf_packer.sv
// -----------------------------------------------------------------------------
// img_bf_packer
// Packs BEATS consecutive DMA beats into one image-buffer word, first beat in
// the LSBs. The final beat is merged combinationally so the caller can register
// the complete word on the same edge that accepts that beat.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_clr             drop any partial word and restart at beat 0
//   i_beat_accept     a beat is transferred this cycle
//   i_beat_data       beat payload
//   o_word_valid      the accepted beat completes a word (combinational)
//   o_word            completed word, valid while o_word_valid is high
// -----------------------------------------------------------------------------
module img_bf_packer
    import img_bf_pkg::*;
#(
    parameter int DMA_WIDTH     = DEF_DMA_WIDTH,
    parameter int BF_DATA_WIDTH = DEF_BF_DATA_WIDTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_beat_accept,
    input  logic [DMA_WIDTH-1:0]     i_beat_data,
    output logic                     o_word_valid,
    output logic [BF_DATA_WIDTH-1:0] o_word
);

    localparam int BEATS = calc_beats(BF_DATA_WIDTH, DMA_WIDTH);
    localparam int CNT_W = calc_cnt_w(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    logic [CNT_W-1:0]         r_beat_cnt;
    logic [BF_DATA_WIDTH-1:0] r_word;
    logic                     w_last_beat;

    assign w_last_beat  = (r_beat_cnt == LAST_BEAT);
    assign o_word_valid = i_beat_accept && w_last_beat;

    // Beat position counter; wraps to 0 after the last beat of each word
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_beat_cnt <= CNT_ZERO;
        end else if (i_beat_accept) begin
            if (w_last_beat) begin
                r_beat_cnt <= CNT_ZERO;
            end else begin
                r_beat_cnt <= r_beat_cnt + CNT_ONE;
            end
        end
    end

    // Beat storage: each accepted beat lands in the slice selected by the counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word <= {BF_DATA_WIDTH{1'b0}};
        end else if (i_beat_accept) begin
            for (int k = 0; k < BEATS; k++) begin
                if (r_beat_cnt == CNT_W'(k)) begin
                    r_word[k*DMA_WIDTH +: DMA_WIDTH] <= i_beat_data;
                end
            end
        end
    end

    // Complete word: stored lower beats plus the beat on the bus in the top slice
    always_comb begin
        o_word = r_word;
        o_word[BF_DATA_WIDTH-1 -: DMA_WIDTH] = i_beat_data;
    end

endmodule

// File: rtl/img_bf_loader.sv
// -----------------------------------------------------------------------------
// img_bf_loader
// Loads a job of (i_word_count+1) image-buffer words from the DMA read port,
// packing BEATS = BF_DATA_WIDTH/DMA_WIDTH beats per word, writing each word to
// consecutive buffer addresses from the latched base, then pulsing o_done.
// Optional feature macro: IMG_BF_PINGPONG_EN (bank-alternating base address,
// adds o_wr_bank).
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start, i_abort             job start (IDLE only), job cancel
//   i_base_addr, i_word_count    job base address and words-minus-one
//   i_dma_valid, i_dma_data      DMA beat in
//   o_dma_ready                  beat accept (state == LOAD)
//   o_bf_wr_en/addr/data         one-cycle image-buffer write
//   o_busy, o_done               job active, job-complete pulse
//   o_wr_bank                    bank of current/last job (pingpong only)
// -----------------------------------------------------------------------------
module img_bf_loader
    import img_bf_pkg::*;
#(
    parameter int DMA_WIDTH       = DEF_DMA_WIDTH,
    parameter int BF_DATA_WIDTH   = DEF_BF_DATA_WIDTH,
    parameter int IMEM_ADDR_WIDTH = DEF_IMEM_ADDR_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [IMEM_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [IMEM_ADDR_WIDTH-1:0] i_word_count,
    input  logic                       i_dma_valid,
    input  logic [DMA_WIDTH-1:0]       i_dma_data,
    output logic                       o_dma_ready,
    output logic                       o_bf_wr_en,
    output logic [IMEM_ADDR_WIDTH-1:0] o_bf_wr_addr,
    output logic [BF_DATA_WIDTH-1:0]   o_bf_wr_data,
    output logic                       o_busy,
    output logic                       o_done
`ifdef IMG_BF_PINGPONG_EN
    ,
    output logic                       o_wr_bank
`endif
);

    localparam int AW = IMEM_ADDR_WIDTH;
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_ZERO = AW'(0);

    generate
        if (!width_ok(BF_DATA_WIDTH, DMA_WIDTH)) begin : g_bad_width
            $error("img_bf_loader: BF_DATA_WIDTH must be a multiple of DMA_WIDTH");
        end
    endgenerate

    bf_state_e r_state;
    bf_state_e w_next_state;

    logic [AW-1:0]            r_base;
    logic [AW-1:0]            r_count;
    logic [AW-1:0]            r_word_idx;
    logic [AW-1:0]            w_start_base;
    logic [AW-1:0]            w_wr_addr;
    logic                     w_beat_accept;
    logic                     w_word_valid;
    logic [BF_DATA_WIDTH-1:0] w_word;
    logic                     w_start_take;
    logic                     w_clr;
    logic                     w_job_end;

`ifdef IMG_BF_PINGPONG_EN
    logic          r_bank;
    logic [AW-2:0] w_addr_low;

    // Bank selects the upper half; wrap stays inside the selected half
    assign w_start_base = {r_bank, i_base_addr[AW-2:0]};
    assign w_addr_low   = r_base[AW-2:0] + r_word_idx[AW-2:0];
    assign w_wr_addr    = {r_base[AW-1], w_addr_low};
`else
    assign w_start_base = i_base_addr;
    assign w_wr_addr    = r_base + r_word_idx;
`endif

    assign o_dma_ready = (r_state == ST_LOAD);
    assign o_busy      = (r_state == ST_LOAD);

    // Abort wins over a coincident beat, so that beat is never accepted
    assign w_beat_accept = (r_state == ST_LOAD) && i_dma_valid && !i_abort;

    img_bf_packer #(
        .DMA_WIDTH     (DMA_WIDTH),
        .BF_DATA_WIDTH (BF_DATA_WIDTH)
    ) u_packer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_clr         (w_clr),
        .i_beat_accept (w_beat_accept),
        .i_beat_data   (i_dma_data),
        .o_word_valid  (w_word_valid),
        .o_word        (w_word)
    );

    // Next-state decode: start in IDLE, abort or final word end LOAD
    always_comb begin
        w_next_state = r_state;
        w_start_take = 1'b0;
        w_clr        = 1'b0;
        w_job_end    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_LOAD;
                    w_start_take = 1'b1;
                    w_clr        = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (i_abort) begin
                    w_next_state = ST_IDLE;
                    w_clr        = 1'b1;
                end else if (w_word_valid && (r_word_idx == r_count)) begin
                    w_next_state = ST_IDLE;
                    w_job_end    = 1'b1;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, job context and registered buffer-write outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_base       <= ADDR_ZERO;
            r_count      <= ADDR_ZERO;
            r_word_idx   <= ADDR_ZERO;
            o_bf_wr_en   <= 1'b0;
            o_bf_wr_addr <= ADDR_ZERO;
            o_bf_wr_data <= {BF_DATA_WIDTH{1'b0}};
            o_done       <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            o_bf_wr_en <= w_word_valid;
            o_done     <= w_job_end;
            if (w_start_take) begin
                r_base     <= w_start_base;
                r_count    <= i_word_count;
                r_word_idx <= ADDR_ZERO;
            end else if (w_word_valid) begin
                r_word_idx <= r_word_idx + ADDR_ONE;
            end
            // Data and address hold between writes
            if (w_word_valid) begin
                o_bf_wr_addr <= w_wr_addr;
                o_bf_wr_data <= w_word;
            end
        end
    end

`ifdef IMG_BF_PINGPONG_EN
    // Bank toggles once per completed job; aborts leave it unchanged
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bank    <= 1'b0;
            o_wr_bank <= 1'b0;
        end else begin
            if (w_job_end) begin
                r_bank <= ~r_bank;
            end
            if (w_start_take) begin
                o_wr_bank <= r_bank;
            end
        end
    end
`endif

endmodule

// File: tb/tb_img_bf_loader.sv
module tb_img_bf_loader;

    localparam int DW = 16;
    localparam int BW = 48;
    localparam int AW = 8;
    localparam int NB = BW / DW;

    logic          clk = 1'b0;
    logic          i_rst, i_start, i_abort, i_dma_valid;
    logic [AW-1:0] i_base_addr, i_word_count;
    logic [DW-1:0] i_dma_data;
    logic          o_dma_ready, o_bf_wr_en, o_busy, o_done;
    logic [AW-1:0] o_bf_wr_addr;
    logic [BW-1:0] o_bf_wr_data;
`ifdef IMG_BF_PINGPONG_EN
    logic          o_wr_bank;
`endif

    always #5 clk = ~clk;

    img_bf_loader dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_base_addr  (i_base_addr),
        .i_word_count (i_word_count),
        .i_dma_valid  (i_dma_valid),
        .i_dma_data   (i_dma_data),
        .o_dma_ready  (o_dma_ready),
        .o_bf_wr_en   (o_bf_wr_en),
        .o_bf_wr_addr (o_bf_wr_addr),
        .o_bf_wr_data (o_bf_wr_data),
        .o_busy       (o_busy),
        .o_done       (o_done)
`ifdef IMG_BF_PINGPONG_EN
        ,
        .o_wr_bank    (o_wr_bank)
`endif
    );

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] count;
        int            gap_mode;    // 0 back-to-back, 1 every other cycle, 2 random
        int            abort_beat;  // abort when this many beats accepted (-1 none)
        int            start_beat;  // spurious i_start at this beat (-1 none)
        int            rst_beat;    // reset at this beat (-1 none)
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_last;
        logic          exp_done;
        logic          exp_bank;
    } vec_t;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [BW-1:0] m_last_data = '0;
    logic          m_bank = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference address: base + word index, wrapping over the full space or a bank half
    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input int w,
                                                 input logic bank);
`ifdef IMG_BF_PINGPONG_EN
        int low;
        low = (int'(base) % (1 << (AW - 1)) + w) % (1 << (AW - 1));
        return AW'(int'(bank) * (1 << (AW - 1)) + low);
`else
        return AW'((int'(base) + w) % (1 << AW));
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"}, o_bf_wr_en, 0);
        chk({tag, "_addr"}, o_bf_wr_addr, 0);
        chk({tag, "_data"}, o_bf_wr_data, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_ready"}, o_dma_ready, 0);
`ifdef IMG_BF_PINGPONG_EN
        chk({tag, "_bank"}, o_wr_bank, 0);
`endif
    endtask

    // Drives one job and checks every cycle against the word/beat model
    task automatic run_job(input vec_t v, output logic [AW-1:0] first_a,
                           output logic [AW-1:0] last_a, output logic done_seen);
        logic [DW-1:0] beats[$];
        logic [BW-1:0] d;
        logic [AW-1:0] a;
        logic          job_bank;
        logic          vld, ab, rs, st, exp_wr, exp_done;
        int            nbeats, acc, cyc, w;
        bit            fin;
        first_a   = '0;
        last_a    = '0;
        done_seen = 1'b0;
        nbeats    = (int'(v.count) + 1) * NB;
        acc       = 0;
        cyc       = 0;
        fin       = 0;
        job_bank  = m_bank;
        for (int i = 0; i < nbeats; i++) beats.push_back(DW'($urandom));
        i_base_addr  = v.base;
        i_word_count = v.count;
        i_start      = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1);
        chk("ready_after_start", o_dma_ready, 1);
`ifdef IMG_BF_PINGPONG_EN
        chk("wr_bank_at_start", o_wr_bank, job_bank);
`endif
        while (!fin) begin
            vld = (v.gap_mode == 0) || (v.gap_mode == 1 && (cyc % 2) == 0) ||
                  (v.gap_mode == 2 && $urandom_range(0, 1) == 1);
            ab = (acc == v.abort_beat);
            rs = (acc == v.rst_beat);
            st = (acc == v.start_beat);
            if (ab) vld = 1'b1;
            if (rs) vld = 1'b0;
            i_dma_valid = vld;
            i_dma_data  = beats[acc];
            i_abort     = ab;
            i_rst       = rs;
            i_start     = st;
            if (st) i_base_addr = 8'h99;
            @(posedge clk); #1;
            cyc++;
            i_abort = 1'b0; i_rst = 1'b0; i_start = 1'b0; i_dma_valid = 1'b0;
            if (rs) begin
                check_all_zero("mid_reset");
                m_bank      = 1'b0;
                m_last_data = '0;
                fin         = 1;
            end else if (ab) begin
                chk("abort_wr_en", o_bf_wr_en, 0);
                chk("abort_done", o_done, 0);
                chk("abort_busy", o_busy, 0);
                fin = 1;
            end else begin
                exp_wr   = 1'b0;
                exp_done = 1'b0;
                if (vld) begin
                    acc++;
                    exp_wr   = ((acc % NB) == 0);
                    exp_done = exp_wr && (acc == nbeats);
                end
                chk("wr_en", o_bf_wr_en, exp_wr);
                chk("done", o_done, exp_done);
                if (exp_wr) begin
                    w = acc / NB - 1;
                    d = '0;
                    for (int k = 0; k < NB; k++) d[k*DW +: DW] = beats[w*NB + k];
                    a = model_addr(v.base, w, job_bank);
                    chk("wr_addr", o_bf_wr_addr, a);
                    chk("wr_data", o_bf_wr_data, d);
                    if (w == 0) first_a = a;
                    last_a      = a;
                    m_last_data = d;
                end else begin
                    chk("data_hold", o_bf_wr_data, m_last_data);
                end
                if (exp_done) begin
                    done_seen = 1'b1;
                    chk("ready_after_done", o_dma_ready, 0);
                    chk("busy_after_done", o_busy, 0);
`ifdef IMG_BF_PINGPONG_EN
                    m_bank = ~m_bank;
`endif
                    fin = 1;
                end
            end
            if (!fin && cyc > nbeats * 4 + 20) begin
                n_vec++;
                n_bad++;
                $display("FAIL timeout: got %0d cycles expected at most %0d", cyc, nbeats * 4 + 20);
                fin = 1;
            end
        end
    endtask

    initial begin
        vec_t          tbl[6];
        vec_t          rv;
        logic [AW-1:0] fa, la;
        logic          dn;
`ifdef IMG_BF_PINGPONG_EN
        tbl[0] = '{8'h05, 8'd0, 0, -1, -1, -1, 8'h05, 8'h05, 1'b1, 1'b0};
        tbl[1] = '{8'h05, 8'd0, 1, -1, -1, -1, 8'h85, 8'h85, 1'b1, 1'b1};
        tbl[2] = '{8'h05, 8'd1, 0,  4, -1, -1, 8'h05, 8'h05, 1'b0, 1'b0};
        tbl[3] = '{8'h05, 8'd0, 0, -1, -1, -1, 8'h05, 8'h05, 1'b1, 1'b0};
        tbl[4] = '{8'h7F, 8'd1, 0, -1, -1, -1, 8'hFF, 8'h80, 1'b1, 1'b1};
        tbl[5] = '{8'h40, 8'd1, 0, -1,  2,  4, 8'h40, 8'h40, 1'b0, 1'b0};
`else
        tbl[0] = '{8'h10, 8'd0, 0, -1, -1, -1, 8'h10, 8'h10, 1'b1, 1'b0};
        tbl[1] = '{8'h10, 8'd1, 1, -1, -1, -1, 8'h10, 8'h11, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 8'd1, 0, -1, -1, -1, 8'hFF, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'h20, 8'd1, 0,  4, -1, -1, 8'h20, 8'h20, 1'b0, 1'b0};
        tbl[4] = '{8'h40, 8'd1, 0, -1,  2,  4, 8'h40, 8'h40, 1'b0, 1'b0};
        tbl[5] = '{8'hFE, 8'd3, 2, -1, -1, -1, 8'hFE, 8'h01, 1'b1, 1'b0};
`endif
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_dma_valid = 1'b0;
        i_base_addr = '0; i_word_count = '0; i_dma_data = '0;
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
        check_all_zero("reset");

        // Fixed vectors from the table
        for (int i = 0; i < 6; i++) begin
            run_job(tbl[i], fa, la, dn);
            chk($sformatf("tbl%0d_first_addr", i), fa, tbl[i].exp_first);
            chk($sformatf("tbl%0d_last_addr", i), la, tbl[i].exp_last);
            chk($sformatf("tbl%0d_done", i), dn, tbl[i].exp_done);
`ifdef IMG_BF_PINGPONG_EN
            if (tbl[i].rst_beat < 0) chk($sformatf("tbl%0d_bank", i), o_wr_bank, tbl[i].exp_bank);
`endif
        end

        // Job right after a reset: fresh beat count, starts at its own base
        rv = '{8'h50, 8'd0, 0, -1, -1, -1, 8'h00, 8'h00, 1'b0, 1'b0};
        run_job(rv, fa, la, dn);
        chk("post_reset_first_addr", fa, model_addr(8'h50, 0, 1'b0));
        chk("post_reset_done", dn, 1);

        // Randomized jobs checked by the model
        for (int j = 0; j < 10; j++) begin
            rv = '{AW'($urandom), AW'($urandom_range(0, 4)), 2, -1, -1, -1,
                   8'h00, 8'h00, 1'b0, 1'b0};
            run_job(rv, fa, la, dn);
            chk($sformatf("rand%0d_done", j), dn, 1);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("idle_end_busy", o_busy, 0);
        chk("idle_end_wr_en", o_bf_wr_en, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/img_bf_loader.md
# img_bf_loader

Parametrised DMA-to-image-buffer loader that replaces the hard-wired 16-to-48-bit image-write path of the layer controller. It accepts a job of N+1 buffer words from a start address. It packs BEATS consecutive DMA beats into each buffer word under a valid/ready handshake. It writes each completed word to the image buffer, then reports completion. It sits between the DMA read port and the image buffer write port, and is kicked by the layer FSM.

## Interface
- DMA_WIDTH, 16: DMA beat width; BF_DATA_WIDTH must be an integer multiple of it.
- BF_DATA_WIDTH, 48: image-buffer word width (DATA_WIDTH*COLUMN_NUM).
- IMEM_ADDR_WIDTH, 8: image-buffer address width.
- BEATS, BF_DATA_WIDTH/DMA_WIDTH (derived, not overridable): beats per buffer word, ≥1.

- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  job start; sampled only in IDLE.
- i_abort  in  1  cancel current job.
- i_base_addr  in  IMEM_ADDR_WIDTH  first write address; latched at start.
- i_word_count  in  IMEM_ADDR_WIDTH  words in job minus one; latched at start.
- i_dma_valid  in  1  beat present.
- i_dma_data  in  DMA_WIDTH  beat payload.
- o_dma_ready  out  1  beat accepted when valid&&ready.
- o_bf_wr_en  out  1  one-cycle write strobe.
- o_bf_wr_addr  out  IMEM_ADDR_WIDTH  write address.
- o_bf_wr_data  out  BF_DATA_WIDTH  packed word.
- o_busy  out  1  high in LOAD.
- o_done  out  1  one-cycle job-complete pulse.
- o_wr_bank  out  1  present only with IMG_BF_PINGPONG_EN.

## Operation
- States: IDLE → LOAD on i_start. LOAD → IDLE on the last beat of the last word, or on i_abort.
- Start latches base, count and bank. It clears the beat counter and word counter. i_start while in LOAD is ignored.
- o_dma_ready and o_busy are decodes of state==LOAD. Beats are accepted only in LOAD.
- Beat k (0..BEATS-1) of a word lands in bits [k*DMA_WIDTH +: DMA_WIDTH]. The first beat goes to the LSBs.
- Accepting beat BEATS-1 registers the full word and issues the buffer write. Address = latched base + word index, modulo 2^IMEM_ADDR_WIDTH (wraps silently).
- After word index reaches i_word_count, the job ends. Words written = i_word_count+1; i_word_count=0 writes one word.
- Abort: takes priority over a coincident beat; that beat is not accepted. The partial word is discarded. No write and no o_done. Return to IDLE.
- Reset at any point: return to IDLE; all outputs 0; counters 0; bank 0.
- Reset value of every output: 0.

## Timing
- Write latency: o_bf_wr_en/addr/data are asserted the cycle after the final beat of a word is accepted, for exactly one cycle. o_bf_wr_data holds its value until the next write.
- o_done asserts in the same cycle as the final word's o_bf_wr_en. By then state is IDLE and o_dma_ready is 0.
- Throughput: with i_dma_valid held high, one buffer word every BEATS cycles and no bubbles between words.
- Gaps in i_dma_valid stall packing only; the beat counter holds.
- i_start may be asserted in the o_done cycle; the new job begins next cycle.

## Configuration
- IMG_BF_PINGPONG_EN defined:
  - Effective base = {bank, i_base_addr[IMEM_ADDR_WIDTH-2:0]}.
  - Bank starts at 0 and toggles on each o_done. Abort does not toggle it.
  - o_wr_bank = bank latched at start of the current/last job.
  - Address wrap is confined to one bank half.
- Not defined:
  - i_base_addr is used as-is and o_wr_bank does not exist.
  - Wrap is over the full address space.

## Structure
- Shared package img_bf_pkg:
  - State enum (IDLE, LOAD).
  - BEATS derivation function.
  - Beat-counter width constant $clog2(BEATS) (min 1).
  - Elaboration check that BF_DATA_WIDTH % DMA_WIDTH == 0.
- Sub-module img_bf_packer:
  - Beat counter and shift-in word register.
  - Inputs: beat-accept and clear.
  - Outputs: word_valid and word.
- The top holds the FSM, address/word counters and bank logic.

## Test plan
- Defaults, base=0x10, count=0, 3 beats 0x1111/0x2222/0x3333 back-to-back → single write addr 0x10 data 0x333322221111; o_done in the same cycle; ready low after.
- count=1, valid toggling every other cycle → writes to 0x10 and 0x11, each one cycle after its 3rd accepted beat; no write on stall cycles.
- base=0xFF, count=1 → writes 0xFF then 0x00 (wrap).
- Abort coincident with the 2nd beat of word 1 → word 0 written, no further write, no o_done, IDLE next cycle; a following start behaves normally.
- i_start pulsed mid-job and i_rst mid-job → start ignored; after reset all outputs 0 and the next job starts at its base with a fresh beat count.
- IMG_BF_PINGPONG_EN, base=0x05, two jobs → first writes 0x05 with o_wr_bank=0, second writes 0x85 with o_wr_bank=1.
